// File: rtl/serializer_pkg.sv
// Shared constants and state encoding for the 4-bit serializer.
package serializer_pkg;

  localparam int WIDTH = 4;
  localparam int CNT_W = 2;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    DONE  = 2'b10
  } state_t;

endpackage

// File: rtl/dff_ar.sv
// Single-bit D flip-flop with asynchronous active-high reset to a
// parameterized value; every state bit of the serializer is one of these.
module dff_ar #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  // storage bit
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= RST_VAL;
    end else begin
      q <= d;
    end
  end

endmodule

// File: rtl/serializer_4bit.sv
// Captures a 4-bit word on start and shifts it out one bit per cycle,
// followed by a one-cycle done pulse.
module serializer_4bit
  import serializer_pkg::*;
#(
  parameter int LSB_FIRST = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  input  logic             start,
  output logic             ready,
  output logic             busy,
  output logic             sout,
  output logic             sout_valid,
  output logic             done
);

  logic [1:0]       state_q;
  state_t           state_r;
  state_t           state_nxt;
  logic [WIDTH-1:0] shreg_r;
  logic [WIDTH-1:0] shreg_nxt;
  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] cnt_nxt;

  assign state_r = state_t'(state_q);

  for (genvar i = 0; i < 2; i++) begin : g_state
    dff_ar #(.RST_VAL(1'b0)) u_ff (
      .clk (clk),
      .rst (rst),
      .d   (state_nxt[i]),
      .q   (state_q[i])
    );
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_shreg
    dff_ar #(.RST_VAL(1'b0)) u_ff (
      .clk (clk),
      .rst (rst),
      .d   (shreg_nxt[i]),
      .q   (shreg_r[i])
    );
  end

  for (genvar i = 0; i < CNT_W; i++) begin : g_cnt
    dff_ar #(.RST_VAL(1'b0)) u_ff (
      .clk (clk),
      .rst (rst),
      .d   (cnt_nxt[i]),
      .q   (cnt_r[i])
    );
  end

  // next state, shift register and bit counter; the counter wraps 3->0 only
  // on the SHIFT-to-DONE edge because it holds in every other state
  always_comb begin
    state_nxt = IDLE;
    shreg_nxt = shreg_r;
    cnt_nxt   = cnt_r;
    case (state_r)
      IDLE: begin
        if (start) begin
          state_nxt = SHIFT;
          shreg_nxt = d;
          cnt_nxt   = {CNT_W{1'b0}};
        end else begin
          state_nxt = IDLE;
        end
      end
      SHIFT: begin
        if (LSB_FIRST != 0) begin
          shreg_nxt = {1'b0, shreg_r[WIDTH-1:1]};
        end else begin
          shreg_nxt = {shreg_r[WIDTH-2:0], 1'b0};
        end
        cnt_nxt = cnt_r + CNT_W'(1);
        if (cnt_r == LAST_CNT) begin
          state_nxt = DONE;
        end else begin
          state_nxt = SHIFT;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign ready      = (state_r == IDLE);
  assign busy       = (state_r == SHIFT);
  assign done       = (state_r == DONE);
  assign sout_valid = busy;
  assign sout       = busy & ((LSB_FIRST != 0) ? shreg_r[0] : shreg_r[WIDTH-1]);

endmodule

// File: tb/tb_serializer_4bit.sv
// Directed bench: one LSB-first and one MSB-first serializer share stimulus.
module tb_serializer_4bit;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] d = 4'h0;
  logic       start = 1'b0;
  logic       ready_l, busy_l, sout_l, sout_valid_l, done_l;
  logic       ready_m, busy_m, sout_m, sout_valid_m, done_m;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [3:0] d;
    logic [3:0] exp_l;  // bit sequence as emitted, first bit in [3]
    logic [3:0] exp_m;
  } vec_t;

  vec_t vecs[7];

  always #5 clk = ~clk;

  serializer_4bit #(.LSB_FIRST(1)) dut_l (
    .clk(clk), .rst(rst), .d(d), .start(start),
    .ready(ready_l), .busy(busy_l), .sout(sout_l),
    .sout_valid(sout_valid_l), .done(done_l)
  );

  serializer_4bit #(.LSB_FIRST(0)) dut_m (
    .clk(clk), .rst(rst), .d(d), .start(start),
    .ready(ready_m), .busy(busy_m), .sout(sout_m),
    .sout_valid(sout_valid_m), .done(done_m)
  );

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ready,busy,valid,done for both DUTs packed together
  function automatic logic [7:0] ctl();
    return {ready_l, busy_l, sout_valid_l, done_l, ready_m, busy_m, sout_valid_m, done_m};
  endfunction

  // Shift-out phase: caller has just passed the capture edge.
  task automatic check_bits(input string name, input logic [3:0] exp_l, input logic [3:0] exp_m);
    for (int i = 0; i < 4; i++) begin
      chk({name, " ctl"}, ctl(), 8'b0110_0110);
      chk({name, " sout_l"}, {7'd0, sout_l}, {7'd0, exp_l[3-i]});
      chk({name, " sout_m"}, {7'd0, sout_m}, {7'd0, exp_m[3-i]});
      tick();
    end
    chk({name, " done"}, ctl(), 8'b0001_0001);
    chk({name, " done sout"}, {6'd0, sout_l, sout_m}, 8'd0);
  endtask

  task automatic run_word(input string name, input logic [3:0] dv,
                          input logic [3:0] exp_l, input logic [3:0] exp_m);
    chk({name, " idle"}, ctl(), 8'b1000_1000);
    d = dv;
    start = 1'b1;
    tick();
    start = 1'b0;
    d = ~dv;
    check_bits(name, exp_l, exp_m);
    tick();
    chk({name, " ready"}, ctl(), 8'b1000_1000);
  endtask

  initial begin
    vecs[0] = '{4'b1011, 4'b1101, 4'b1011};
    vecs[1] = '{4'b0010, 4'b0100, 4'b0010};
    vecs[2] = '{4'b1010, 4'b0101, 4'b1010};
    vecs[3] = '{4'b0101, 4'b1010, 4'b0101};
    vecs[4] = '{4'b0000, 4'b0000, 4'b0000};
    vecs[5] = '{4'b1111, 4'b1111, 4'b1111};
    vecs[6] = '{4'b1000, 4'b0001, 4'b1000};

    // S1: reset before any clock edge
    #2 rst = 1'b1;
    #1;
    chk("s1 ctl", ctl(), 8'b1000_1000);
    chk("s1 sout", {6'd0, sout_l, sout_m}, 8'd0);
    tick();
    tick();
    rst = 1'b0;

    // first start right after reset release; S2/S3 are vecs[0]
    for (int i = 0; i < 7; i++) begin
      run_word($sformatf("vec%0d", i), vecs[i].d, vecs[i].exp_l, vecs[i].exp_m);
    end

    // S4: start pulsed and d changed during SHIFT
    d = 4'h2;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("s4 ctl", ctl(), 8'b0110_0110);
      chk("s4 sout_l", {7'd0, sout_l}, {7'd0, (i == 1) ? 1'b1 : 1'b0});
      d = 4'hF;
      start = (i < 3) ? 1'b1 : 1'b0;
      tick();
    end
    start = 1'b0;
    chk("s4 done", ctl(), 8'b0001_0001);
    tick();
    chk("s4 ready", ctl(), 8'b1000_1000);
    tick();
    chk("s4 no restart", ctl(), 8'b1000_1000);

    // S5: start held high, words 6 cycles apart
    begin
      int first_t;
      int second_t;
      d = 4'hA;
      start = 1'b1;
      tick();
      first_t = $time;
      d = 4'h5;
      check_bits("s5 w0", 4'b0101, 4'b1010);
      tick();
      chk("s5 gap ready", ctl(), 8'b1000_1000);
      tick();
      second_t = $time;
      d = 4'h0;
      check_bits("s5 w1", 4'b1010, 4'b0101);
      start = 1'b0;
      chk("s5 period", 8'((second_t - first_t) / 10), 8'd6);
      tick();
      tick();
      chk("s5 stopped", ctl(), 8'b1000_1000);
    end

    // S6: reset after the 2nd bit aborts the word
    d = 4'b0110;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("s6 b0", {7'd0, sout_l}, 8'd0);
    tick();
    chk("s6 b1", {7'd0, sout_l}, 8'd1);
    #2 rst = 1'b1;
    #1;
    chk("s6 abort ctl", ctl(), 8'b1000_1000);
    chk("s6 abort sout", {6'd0, sout_l, sout_m}, 8'd0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      chk("s6 no done", ctl(), 8'b1000_1000);
    end
    rst = 1'b0;
    run_word("s6 fresh", 4'b1001, 4'b1001, 4'b1001);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
